// File: rtl/superscalar_decode_pkg.sv
// Shared processor types for the decode stage: ISA field positions, opcode/ALU/branch enums,
// fetch/decode/register-read payload structs and a sign-extension helper.
package superscalar_decode_pkg;

   localparam int SUPER_SCALAR_WIDTH_DEFAULT = 2;
   localparam int REG_ADDR_W                 = 6;
   localparam int WORD_WIDTH                 = 32;

   // Instruction field positions; upper-format rd sits at [9:4], register-op rd at [12:7]
   localparam int FUNCT_LSB    = 4;
   localparam int RD_LSB_UPPER = 4;
   localparam int RD_LSB_OP    = 7;
   localparam int RS1_LSB      = 13;
   localparam int RS2_LSB      = 19;

   typedef logic [WORD_WIDTH-1:0] Word;

   typedef enum logic [3:0] {
      OPCODE_LUI         = 4'd0,
      OPCODE_JAL         = 4'd1,
      OPCODE_JALR        = 4'd2,
      OPCODE_LOAD        = 4'd3,
      OPCODE_STORE       = 4'd4,
      OPCODE_BRANCH      = 4'd5,
      OPCODE_OP          = 4'd6,
      OPCODE_OP_IMM      = 4'd7,
      OPCODE_UNSUPPORTED = 4'hF
   } Opcode;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } AluOp;

   typedef enum logic [2:0] {
      BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT, BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU
   } BranchOp;

   typedef enum logic {ST_IDLE, ST_ISSUE} DecodeState;

   typedef struct packed {
      logic [31:0] instruction;
      Word         program_counter;
   } FetchResult;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] register_index;
   } RegisterFileReadRequest;

   typedef struct packed {
      Opcode                 instruction_type;
      AluOp                  alu_op;
      BranchOp               branch_op;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  writes_rd;
      logic                  reads_rs1;
      logic                  reads_rs2;
      Word                   immediate;
      Word                   source_value_1;
      Word                   source_value_2;
      Word                   program_counter;
   } DecodeResult;

   function automatic Word sign_extend(input Word value, input int bits);
      Word shifted;
      shifted = value << (WORD_WIDTH - bits);
      return Word'($signed(shifted) >>> (WORD_WIDTH - bits));
   endfunction

endpackage

// File: rtl/superscalar_decode_lane.sv
// Combinational single-instruction decode; unknown opcode/funct yields UNSUPPORTED with no
// register use. Source indices come out before the read data comes back, so no loop forms.
module decode_lane
   import superscalar_decode_pkg::*;
(
   input  FetchResult            i_fetch,
   input  Word                   i_rs1_value,
   input  Word                   i_rs2_value,
   output logic [REG_ADDR_W-1:0] o_rs1_index,
   output logic [REG_ADDR_W-1:0] o_rs2_index,
   output DecodeResult           o_result
);

   logic [31:0] w_instr;
   logic [2:0]  w_funct;
   DecodeResult w_dec;

   assign w_instr = i_fetch.instruction;
   assign w_funct = w_instr[FUNCT_LSB +: 3];

   always_comb begin
      w_dec                  = '0;
      w_dec.program_counter  = i_fetch.program_counter;
      w_dec.instruction_type = OPCODE_UNSUPPORTED;
      case (w_instr[3:0])
         OPCODE_LUI: begin
            w_dec.instruction_type = OPCODE_LUI;
            w_dec.writes_rd        = 1'b1;
            w_dec.rd               = w_instr[RD_LSB_UPPER +: REG_ADDR_W];
            w_dec.immediate        = {w_instr[31:10], 10'b0};
         end
         OPCODE_JAL: begin
            w_dec.instruction_type = OPCODE_JAL;
            w_dec.writes_rd        = 1'b1;
            w_dec.rd               = w_instr[RD_LSB_UPPER +: REG_ADDR_W];
            w_dec.immediate        = sign_extend({10'b0, w_instr[31:10]}, 22);
         end
         OPCODE_JALR, OPCODE_LOAD: begin
            w_dec.instruction_type = Opcode'(w_instr[3:0]);
            w_dec.writes_rd        = 1'b1;
            w_dec.rd               = w_instr[RD_LSB_UPPER +: REG_ADDR_W];
            w_dec.reads_rs1        = 1'b1;
            w_dec.rs1              = w_instr[RS1_LSB +: REG_ADDR_W];
            w_dec.immediate        = sign_extend({19'b0, w_instr[31:19]}, 13);
         end
         OPCODE_STORE: begin
            w_dec.instruction_type = OPCODE_STORE;
            w_dec.reads_rs1        = 1'b1;
            w_dec.reads_rs2        = 1'b1;
            w_dec.rs1              = w_instr[RS1_LSB +: REG_ADDR_W];
            w_dec.rs2              = w_instr[RS2_LSB +: REG_ADDR_W];
            w_dec.immediate        = sign_extend({16'b0, w_instr[31:25], w_instr[12:4]}, 16);
         end
         OPCODE_BRANCH: begin
            if (w_funct < 3'd6) begin
               w_dec.instruction_type = OPCODE_BRANCH;
               w_dec.branch_op        = BranchOp'(w_funct);
               w_dec.reads_rs1        = 1'b1;
               w_dec.reads_rs2        = 1'b1;
               w_dec.rs1              = w_instr[RS1_LSB +: REG_ADDR_W];
               w_dec.rs2              = w_instr[RS2_LSB +: REG_ADDR_W];
               w_dec.immediate        = sign_extend({19'b0, w_instr[31:25], w_instr[12:7]}, 13);
            end
         end
         OPCODE_OP: begin
            w_dec.instruction_type = OPCODE_OP;
            w_dec.alu_op           = AluOp'(w_funct);
            w_dec.writes_rd        = 1'b1;
            w_dec.rd               = w_instr[RD_LSB_OP +: REG_ADDR_W];
            w_dec.reads_rs1        = 1'b1;
            w_dec.reads_rs2        = 1'b1;
            w_dec.rs1              = w_instr[RS1_LSB +: REG_ADDR_W];
            w_dec.rs2              = w_instr[RS2_LSB +: REG_ADDR_W];
         end
         OPCODE_OP_IMM: begin
            // Subtract-immediate has no encoding; add a negative immediate instead
            if (w_funct != ALU_SUB) begin
               w_dec.instruction_type = OPCODE_OP_IMM;
               w_dec.alu_op           = AluOp'(w_funct);
               w_dec.writes_rd        = 1'b1;
               w_dec.rd               = w_instr[RD_LSB_OP +: REG_ADDR_W];
               w_dec.reads_rs1        = 1'b1;
               w_dec.rs1              = w_instr[RS1_LSB +: REG_ADDR_W];
               w_dec.immediate        = sign_extend({19'b0, w_instr[31:19]}, 13);
            end
         end
         default: ;
      endcase
   end

   assign o_rs1_index = w_dec.reads_rs1 ? w_dec.rs1 : '0;
   assign o_rs2_index = w_dec.reads_rs2 ? w_dec.rs2 : '0;

   always_comb begin
      o_result                = w_dec;
      o_result.source_value_1 = (w_dec.reads_rs1 && w_dec.rs1 != '0) ? i_rs1_value : '0;
      o_result.source_value_2 = (w_dec.reads_rs2 && w_dec.rs2 != '0) ? i_rs2_value : '0;
   end

endmodule

// File: rtl/superscalar_decode.sv
// Superscalar decode: holds one fetch bundle, issues RAW-free lane groups with 1-cycle registered
// output, stalls fetch while lanes pend or execute backpressures. `DECODE_WB_BYPASS_EN adds WB bypass.
module superscalar_decode
   import superscalar_decode_pkg::*;
#(
   parameter int SUPER_SCALAR_WIDTH = SUPER_SCALAR_WIDTH_DEFAULT,
   parameter int REG_ADDR_WIDTH     = REG_ADDR_W
)
(
   input  logic                                           clk_in,
   input  logic                                           rst_in,
   input  logic                                           flush_in,
   output logic                                           fetch_ready_out,
   input  logic                                           fetch_valid_in,
   input  FetchResult [SUPER_SCALAR_WIDTH-1:0]            fetch_payload_in,
   input  logic [SUPER_SCALAR_WIDTH-1:0]                  fetch_lane_mask_in,
   input  logic                                           execute_ready_in,
   output logic                                           execute_valid_out,
   output DecodeResult [SUPER_SCALAR_WIDTH-1:0]           execute_payload_out,
   output logic [SUPER_SCALAR_WIDTH-1:0]                  execute_lane_mask_out,
   output RegisterFileReadRequest [SUPER_SCALAR_WIDTH-1:0] register_file_reg0_read_request_out,
   output RegisterFileReadRequest [SUPER_SCALAR_WIDTH-1:0] register_file_reg1_read_request_out,
   input  Word [SUPER_SCALAR_WIDTH-1:0]                   register_file_reg0_read_response_in,
   input  Word [SUPER_SCALAR_WIDTH-1:0]                   register_file_reg1_read_response_in
`ifdef DECODE_WB_BYPASS_EN
   ,
   input  logic                                           writeback_valid_in,
   input  logic [REG_ADDR_WIDTH-1:0]                      writeback_register_in,
   input  Word                                            writeback_value_in
`endif
);

   localparam int W = SUPER_SCALAR_WIDTH;

   DecodeState                  r_state;
   logic [W-1:0]                r_pending;
   FetchResult [W-1:0]          r_hold;
   logic                        r_out_vld;
   logic [W-1:0]                r_out_mask;
   DecodeResult [W-1:0]         r_out_payload;

   logic                        w_out_free;
   logic                        w_fetch_fire;
   logic [W-1:0]                w_issue;
   logic [W-1:0]                w_remaining;
   logic                        w_stop;
   logic                        w_hit;
   DecodeResult                 w_dec     [W];
   logic [REG_ADDR_W-1:0]       w_rs1_idx [W];
   logic [REG_ADDR_W-1:0]       w_rs2_idx [W];
   Word                         w_rs1_val [W];
   Word                         w_rs2_val [W];
   logic [REG_ADDR_WIDTH-1:0]   w_rd      [W];
   logic [REG_ADDR_WIDTH-1:0]   w_rs1     [W];
   logic [REG_ADDR_WIDTH-1:0]   w_rs2     [W];

   assign w_out_free      = !r_out_vld || execute_ready_in;
   assign fetch_ready_out = (r_state == ST_IDLE) && w_out_free;
   assign w_fetch_fire    = fetch_ready_out && fetch_valid_in;

   for (genvar g = 0; g < W; g++) begin : g_lane
      decode_lane u_lane (
         .i_fetch     (r_hold[g]),
         .i_rs1_value (w_rs1_val[g]),
         .i_rs2_value (w_rs2_val[g]),
         .o_rs1_index (w_rs1_idx[g]),
         .o_rs2_index (w_rs2_idx[g]),
         .o_result    (w_dec[g])
      );

      assign w_rd[g]  = w_dec[g].rd;
      assign w_rs1[g] = w_dec[g].rs1;
      assign w_rs2[g] = w_dec[g].rs2;
      assign register_file_reg0_read_request_out[g].register_index = r_pending[g] ? w_rs1_idx[g] : '0;
      assign register_file_reg1_read_request_out[g].register_index = r_pending[g] ? w_rs2_idx[g] : '0;

`ifdef DECODE_WB_BYPASS_EN
      assign w_rs1_val[g] = (writeback_valid_in && writeback_register_in != '0 &&
                             writeback_register_in == w_rs1_idx[g]) ? writeback_value_in
                                                                    : register_file_reg0_read_response_in[g];
      assign w_rs2_val[g] = (writeback_valid_in && writeback_register_in != '0 &&
                             writeback_register_in == w_rs2_idx[g]) ? writeback_value_in
                                                                    : register_file_reg1_read_response_in[g];
`else
      assign w_rs1_val[g] = register_file_reg0_read_response_in[g];
      assign w_rs2_val[g] = register_file_reg1_read_response_in[g];
`endif
   end

   // Group grows from the lowest pending lane until a lane reads an rd written earlier in the group
   always_comb begin
      w_issue = '0;
      w_stop  = 1'b0;
      w_hit   = 1'b0;
      for (int i = 0; i < W; i++) begin
         w_hit = 1'b0;
         for (int m = 0; m < W; m++) begin
            if (m < i && w_issue[m] && w_dec[m].writes_rd && w_rd[m] != '0 &&
                ((w_dec[i].reads_rs1 && w_rs1[i] == w_rd[m]) ||
                 (w_dec[i].reads_rs2 && w_rs2[i] == w_rd[m])))
               w_hit = 1'b1;
         end
         if (r_pending[i] && !w_stop) begin
            if (w_hit) w_stop = 1'b1;
            else       w_issue[i] = 1'b1;
         end
      end
   end

   assign w_remaining = r_pending & ~w_issue;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state       <= ST_IDLE;
         r_pending     <= '0;
         r_hold        <= '0;
         r_out_vld     <= 1'b0;
         r_out_mask    <= '0;
         r_out_payload <= '0;
      end else if (flush_in) begin
         r_state    <= ST_IDLE;
         r_pending  <= '0;
         r_out_vld  <= 1'b0;
         r_out_mask <= '0;
      end else begin
         if (w_out_free) begin
            if (r_state == ST_ISSUE) begin
               r_out_vld  <= 1'b1;
               r_out_mask <= w_issue;
               for (int i = 0; i < W; i++)
                  r_out_payload[i] <= w_issue[i] ? w_dec[i] : '0;
               r_pending <= w_remaining;
               if (w_remaining == '0) r_state <= ST_IDLE;
            end else begin
               r_out_vld  <= 1'b0;
               r_out_mask <= '0;
            end
         end
         // Only possible while idle, so it never collides with the issue update above
         if (w_fetch_fire) begin
            r_hold    <= fetch_payload_in;
            r_pending <= fetch_lane_mask_in;
            r_state   <= (fetch_lane_mask_in != '0) ? ST_ISSUE : ST_IDLE;
         end
      end
   end

   assign execute_valid_out     = r_out_vld;
   assign execute_lane_mask_out = r_out_mask;
   assign execute_payload_out   = r_out_payload;

endmodule
